// File: rtl/thermo_spi_rx_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | thermo_spi_pkg                                                       |
// | Shared types and helpers for the thermocouple SPI receive master.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package thermo_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int TC_FRAME_BITS = 32;

  // Width of a counter running 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/thermo_spi_rx_master_clk_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_clk_div                                                          |
// | Generates idle-low sclk and strobes marking the edges it toggles on. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_clk_div
  import thermo_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int               c_div_w    = cnt_width(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  logic [c_div_w-1:0] r_div_cnt;
  logic               r_sclk;
  logic               w_terminal;

  // Strobes are true on the clk edge that toggles sclk, so the caller acts in step with it.
  assign w_terminal = en && (r_div_cnt == c_div_last);
  assign rise_tick  = w_terminal && !r_sclk;
  assign fall_tick  = w_terminal && r_sclk;
  assign sclk       = r_sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (!en) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_terminal) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/thermo_spi_rx_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | thermo_spi_rx_master                                                 |
// | Mode-0 receive-only SPI master reading one converter frame per req.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module thermo_spi_rx_master
  import thermo_spi_pkg::*;
#(
  parameter int FRAME_BITS = TC_FRAME_BITS,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_ena,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  spi_not_busy,
  output logic [FRAME_BITS-1:0] spi_rx_data,
  output logic                  frame_done
);

  localparam int c_bit_w     = $clog2(FRAME_BITS + 1);
  localparam int c_phase_max = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int c_phase_w   = cnt_width(c_phase_max);

  localparam logic [c_bit_w-1:0]   c_bits       = c_bit_w'(FRAME_BITS);
  localparam logic [c_phase_w-1:0] c_setup_last = c_phase_w'(CS_SETUP - 1);
  localparam logic [c_phase_w-1:0] c_hold_last  = c_phase_w'(CS_HOLD - 1);

  spi_state_t            r_state;
  logic [c_phase_w-1:0]  r_phase_cnt;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic                  r_cs_n;
  logic                  r_not_busy;
  logic                  r_frame_done;

  logic                  w_div_en;
  logic                  w_rise;
  logic                  w_fall;
  logic [FRAME_BITS-1:0] w_shift_next;

  assign w_div_en = (r_state == SHIFT);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (w_div_en),
    .rise_tick (w_rise),
    .fall_tick (w_fall),
    .sclk      (sclk)
  );

  generate
    if (FRAME_BITS == 1) begin : g_shift_single
      assign w_shift_next = miso;
    end else begin : g_shift_multi
      assign w_shift_next = {r_shift[FRAME_BITS-2:0], miso};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_phase_cnt  <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_cs_n       <= 1'b1;
      r_not_busy   <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_phase_cnt <= '0;
          r_bit_cnt   <= '0;
          if (spi_ena) begin
            r_state    <= SETUP;
            r_cs_n     <= 1'b0;
            r_not_busy <= 1'b0;
            r_shift    <= '0;
          end
        end
        SETUP: begin
          if (r_phase_cnt == c_setup_last) begin
            r_phase_cnt <= '0;
            r_state     <= SHIFT;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (w_rise) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          // The last bit was sampled on the preceding rise; leave once sclk is back low.
          if (w_fall && (r_bit_cnt == c_bits)) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_phase_cnt == c_hold_last) begin
            r_phase_cnt  <= '0;
            r_rx_data    <= r_shift;
            r_cs_n       <= 1'b1;
            r_not_busy   <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign cs_n         = r_cs_n;
  assign spi_not_busy = r_not_busy;
  assign spi_rx_data  = r_rx_data;
  assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_thermo_spi_rx_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_thermo_spi_rx_master                                              |
// | Self-checking bench: converter models feed two DUTs, data scoreboard.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_thermo_spi_rx_master;

  typedef struct {
    logic [31:0] pattern;
    logic        toggle;
    int          exp_lat;
    int          exp_period;
    int          exp_rises;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_ena = 1'b0;
  logic        miso = 1'b0;
  logic        sclk, cs_n, spi_not_busy, frame_done;
  logic [31:0] spi_rx_data;

  logic        spi_ena2 = 1'b0;
  logic        miso2 = 1'b0;
  logic        sclk2, cs_n2, spi_not_busy2, frame_done2;
  logic [31:0] spi_rx_data2;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] pat_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pat2_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] sr = '0;
  logic [31:0] sr2 = '0;

  always #5 clk = ~clk;

  thermo_spi_rx_master dut (
    .clk          (clk),
    .rst          (rst),
    .spi_ena      (spi_ena),
    .miso         (miso),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .spi_not_busy (spi_not_busy),
    .spi_rx_data  (spi_rx_data),
    .frame_done   (frame_done)
  );

  thermo_spi_rx_master #(
    .FRAME_BITS (32),
    .CLK_DIV    (1),
    .CS_SETUP   (3),
    .CS_HOLD    (2)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .spi_ena      (spi_ena2),
    .miso         (miso2),
    .sclk         (sclk2),
    .cs_n         (cs_n2),
    .spi_not_busy (spi_not_busy2),
    .spi_rx_data  (spi_rx_data2),
    .frame_done   (frame_done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Converter models: load a frame when cs_n falls, present MSB, advance on sclk falling edges.
  always @(negedge cs_n) begin
    if (pat_q.size() > 0) begin
      sr = pat_q.pop_front();
      exp_q.push_back(sr);
    end else begin
      sr = '0;
    end
    miso = sr[31];
  end
  always @(negedge sclk) if (!cs_n) begin
    sr   = sr << 1;
    miso = sr[31];
  end

  always @(negedge cs_n2) begin
    if (pat2_q.size() > 0) begin
      sr2 = pat2_q.pop_front();
      exp2_q.push_back(sr2);
    end else begin
      sr2 = '0;
    end
    miso2 = sr2[31];
  end
  always @(negedge sclk2) if (!cs_n2) begin
    sr2   = sr2 << 1;
    miso2 = sr2[31];
  end

  // Scoreboards: every completed frame must match the oldest outstanding pattern.
  always @(negedge clk) if (rst && frame_done) begin
    if (exp_q.size() == 0) check("unexpected_frame", spi_rx_data, 32'hDEAD_BEEF ^ spi_rx_data);
    else                   check("frame_data", spi_rx_data, exp_q.pop_front());
  end
  always @(negedge clk) if (rst && frame_done2) begin
    if (exp2_q.size() == 0) check("unexpected_frame2", spi_rx_data2, 32'hDEAD_BEEF ^ spi_rx_data2);
    else                    check("frame_data2", spi_rx_data2, exp2_q.pop_front());
  end

  task automatic run_frame(input vec_t v);
    int   lat, cs_low, rises, fd, r1, r2;
    logic prev;
    lat = -1; cs_low = 0; rises = 0; fd = 0; r1 = -1; r2 = -1;
    pat_q.push_back(v.pattern);
    @(negedge clk); spi_ena = 1'b1;
    @(posedge clk); #1;
    spi_ena = v.toggle;
    if (!cs_n) cs_low++;
    prev = sclk;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (v.toggle) spi_ena = (k < 100) ? ~spi_ena : 1'b0;
      if (!cs_n) cs_low++;
      if (frame_done) fd++;
      if (sclk && !prev) begin
        rises++;
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
      prev = sclk;
      if (spi_not_busy) begin
        lat = k;
        break;
      end
    end
    spi_ena = 1'b0;
    @(posedge clk); #1;
    if (frame_done) fd++;
    check("latency", lat, v.exp_lat);
    check("cs_low_cycles", cs_low, v.exp_lat);
    check("sclk_rises", rises, v.exp_rises);
    check("sclk_period", r2 - r1, v.exp_period);
    check("frame_done_width", fd, 1);
  endtask

  task automatic run_frame2(input logic [31:0] pat);
    int   lat, rises, r1, r2;
    logic prev;
    lat = -1; rises = 0; r1 = -1; r2 = -1;
    pat2_q.push_back(pat);
    @(negedge clk); spi_ena2 = 1'b1;
    @(posedge clk); #1;
    spi_ena2 = 1'b0;
    prev = sclk2;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (sclk2 && !prev) begin
        rises++;
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
      prev = sclk2;
      if (spi_not_busy2) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    check("latency2", lat, 69);
    check("sclk_rises2", rises, 32);
    check("sclk_period2", r2 - r1, 2);
  endtask

  vec_t vecs[6];

  initial begin
    int n, lowc, highc, rises;
    logic prev;

    vecs[0] = '{32'hA5C3_0F81, 1'b0, 130, 4, 32};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 130, 4, 32};
    vecs[2] = '{32'h0000_0000, 1'b0, 130, 4, 32};
    vecs[3] = '{32'h8000_0001, 1'b0, 130, 4, 32};
    vecs[4] = '{32'h3C96_E17A, 1'b1, 130, 4, 32};
    vecs[5] = '{32'h5A5A_A5A5, 1'b1, 130, 4, 32};

    #2 rst = 1'b0;
    #1;
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_not_busy", spi_not_busy, 1'b1);
    check("rst_rx_data", spi_rx_data, 32'h0);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Back-to-back frames with spi_ena held high.
    pat_q.push_back(32'hFFFF_0000);
    pat_q.push_back(32'h0000_FFFF);
    @(negedge clk); spi_ena = 1'b1;
    n = 0;
    while (cs_n && n < 10) begin @(posedge clk); #1; n++; end
    lowc = 0;
    while (!cs_n && lowc < 400) begin @(posedge clk); #1; lowc++; end
    check("b2b_first_low", lowc, 130);
    highc = 0;
    while (cs_n && highc < 10) begin @(posedge clk); #1; highc++; end
    check("b2b_gap", highc, 1);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_hold_data", spi_rx_data, 32'hFFFF_0000);
    spi_ena = 1'b0;
    n = 0;
    while (!spi_not_busy && n < 400) begin @(posedge clk); #1; n++; end
    check("b2b_second_done", spi_not_busy, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("b2b_no_third", cs_n, 1'b1);
    check("b2b_data2", spi_rx_data, 32'h0000_FFFF);

    // Reset in the middle of a frame.
    pat_q.push_back(32'h1234_5678);
    @(negedge clk); spi_ena = 1'b1;
    @(posedge clk); #1;
    spi_ena = 1'b0;
    rises = 0; n = 0; prev = sclk;
    while (rises < 10 && n < 200) begin
      @(posedge clk); #1; n++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    check("abort_rises", rises, 10);
    #2 rst = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_not_busy", spi_not_busy, 1'b1);
    check("abort_rx_data", spi_rx_data, 32'h0);
    check("abort_frame_done", frame_done, 1'b0);
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(vecs[0]);

    // Fast divider, longer setup and hold.
    run_frame2(32'h8000_0001);
    run_frame2(32'h7F00_FF01);

    repeat (3) @(posedge clk);
    #1;
    check("pending_frames", exp_q.size(), 0);
    check("pending_frames2", exp2_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
